// File: rtl/seq_mon_pkg.sv
// Shared constants and types for the A/B/C/D sequence monitor.
package seq_mon_pkg;

  // Default consecutive-high lengths for the three antecedent sequences.
  localparam int LEN_A_DEF = 3;
  localparam int LEN_B_DEF = 4;
  localparam int LEN_C_DEF = 5;

  // Default widths of the cycle index and the failure counter.
  localparam int CYC_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Per-line tail-end match flags, packed {c,b,a} so bit 0 is the A match.
  typedef struct packed {
    logic c;
    logic b;
    logic a;
  } trig_t;

endpackage

// File: rtl/seq_or_monitor_if.sv
// Trace and verdict bundle between the trace stage and the sequence monitor.
//
// There is no valid/ready handshake: every field is valid on every cycle.
// The trace source (master) drives a/b/c/d, and they are sampled at each
// rising clock edge. The monitor (slave) drives the verdict fields from
// registers, so they are stable for the whole cycle after the edge that
// updated them.
interface seq_or_monitor_if
  import seq_mon_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             a;
  logic             b;
  logic             c;
  logic             d;
  trig_t            trig;
  logic             fail;
  logic             fail_seen;
  logic [CNT_W-1:0] fail_cnt;
  logic [CYC_W-1:0] first_fail;

  modport master (
    output a, b, c, d,
    input  trig, fail, fail_seen, fail_cnt, first_fail
  );

  modport slave (
    input  a, b, c, d,
    output trig, fail, fail_seen, fail_cnt, first_fail
  );

endinterface

// File: rtl/seq_run_detector.sv
// Tail-end detector for x[*LEN]: counts consecutive high samples (saturating
// at LEN) and flags every cycle that completes a run of at least LEN highs.
module seq_run_detector #(
  parameter int LEN = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic x,
  output logic match
);

  localparam int            RW     = $clog2(LEN + 1);
  localparam logic [RW-1:0] LEN_V  = RW'(LEN);
  localparam logic [RW-1:0] LEN_M1 = RW'(LEN - 1);

  // Number of consecutive high samples strictly before the current cycle.
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;

  // Next run length: grow while x stays high (capped at LEN), clear on low.
  always_comb begin
    run_d = '0;
    if (x) begin
      run_d = (run_q == LEN_V) ? LEN_V : run_q + RW'(1);
    end
  end

  // Run counter register; reset discards any partial run.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  // Current sample completes a run of LEN; overlapping matches repeat each
  // cycle while x stays high.
  assign match = x && (run_q >= LEN_M1);

endmodule

// File: rtl/seq_or_monitor.sv
// Downstream checker for "A[*LEN_A] or B[*LEN_B] or C[*LEN_C] |=> D".
// Reports violations as a one-cycle pulse, a sticky flag, a saturating
// count and the cycle index of the first violating cycle.
module seq_or_monitor
  import seq_mon_pkg::*;
#(
  parameter int LEN_A = LEN_A_DEF,
  parameter int LEN_B = LEN_B_DEF,
  parameter int LEN_C = LEN_C_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  seq_or_monitor_if.slave   bus
);

  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-line sequence matches for the current cycle.
  trig_t match;

  seq_run_detector #(.LEN(LEN_A)) u_run_a (
    .clock  (clock),
    .resetn (resetn),
    .x      (bus.a),
    .match  (match.a)
  );

  seq_run_detector #(.LEN(LEN_B)) u_run_b (
    .clock  (clock),
    .resetn (resetn),
    .x      (bus.b),
    .match  (match.b)
  );

  seq_run_detector #(.LEN(LEN_C)) u_run_c (
    .clock  (clock),
    .resetn (resetn),
    .x      (bus.c),
    .match  (match.c)
  );

  // Any match opens a single obligation for the next cycle; simultaneous
  // matches collapse into one.
  logic trigger;
  logic violation;

  // Obligation state and reporting registers.
  logic             pend_q,  pend_d;
  logic [CYC_W-1:0] cyc_q,   cyc_d;
  trig_t            trig_q,  trig_d;
  logic             fail_q,  fail_d;
  logic             seen_q,  seen_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CYC_W-1:0] first_q, first_d;

  assign trigger   = match.a | match.b | match.c;
  // The obligation opened last cycle is checked against d now; a trigger in
  // this same cycle is independent and only affects the next cycle.
  assign violation = pend_q && !bus.d;

  // Next-state: cycle index, obligation and violation bookkeeping.
  always_comb begin
    pend_d  = trigger;
    trig_d  = match;
    fail_d  = violation;
    cyc_d   = (cyc_q == CYC_MAX) ? CYC_MAX : cyc_q + CYC_W'(1);
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (violation) begin
      seen_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Only the earliest violation since reset is timestamped.
      if (!seen_q) begin
        first_d = cyc_q;
      end
    end
  end

  // State registers; reset drops any pending obligation so no verdict is
  // ever produced for a trigger seen before reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend_q  <= 1'b0;
      cyc_q   <= '0;
      trig_q  <= '0;
      fail_q  <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      pend_q  <= pend_d;
      cyc_q   <= cyc_d;
      trig_q  <= trig_d;
      fail_q  <= fail_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign bus.trig       = trig_q;
  assign bus.fail       = fail_q;
  assign bus.fail_seen  = seen_q;
  assign bus.fail_cnt   = cnt_q;
  assign bus.first_fail = first_q;

endmodule
